if_fetch_queue: RTL and testbench
=================================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL take parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL take parameter QDEPTH, default 2: instruction queue entries; a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port rom_ce_o, output, 1: instruction ROM chip enable, 1 = enabled.
REQ-006 SHALL have port rom_addr_o, output, 32: byte address to the ROM; equals the current PC.
REQ-007 SHALL have port rom_inst_i, input, 32: ROM read data, combinational from rom_addr_o in the same cycle.
REQ-008 SHALL have port flush_i, input, 1: exception flush request.
REQ-009 SHALL have port flush_pc_i, input, 32: exception handler address.
REQ-010 SHALL have port branch_flag_i, input, 1: taken-branch redirect from decode.
REQ-011 SHALL have port branch_target_i, input, 32: branch target address.
REQ-012 SHALL have port id_valid_o, output, 1: queue head holds a valid instruction.
REQ-013 SHALL have port id_ready_i, input, 1: decode accepts the head this cycle.
REQ-014 SHALL have port id_pc_o, output, 32: PC of the head entry.
REQ-015 SHALL have port id_inst_o, output, 32: instruction word of the head entry.

Function
REQ-016 SHALL implement a two-state FSM: IDLE (after reset) and FETCH; IDLE->FETCH unconditionally on the first clock edge after rst deasserts; FETCH is held until reset.
REQ-017 SHALL drive rom_ce_o=0 in IDLE; in FETCH, rom_ce_o=1 iff (count<QDEPTH or pop this cycle) and no redirect is active this cycle.
REQ-018 SHALL define pop = id_valid_o & id_ready_i, and push = rom_ce_o.
REQ-019 SHALL, on push, write {pc, rom_inst_i} at the tail and set pc <= pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-020 SHALL allow push and pop in the same cycle when the queue is full; count is then unchanged.
REQ-021 SHALL hold pc and the queue contents when rom_ce_o=0 with no redirect (queue full, decode stalled).
REQ-022 SHALL drive id_valid_o = (count!=0), with id_pc_o and id_inst_o taken from the head entry; id_pc_o and id_inst_o SHALL be 32'h0 when the queue is empty.
REQ-023 SHALL hold the head entry stable while id_valid_o=1 and id_ready_i=0.
REQ-024 SHALL treat flush_i or branch_flag_i as a redirect: queue emptied (count<=0, pointers<=0), no push, no pop, pc <= new target with bits [1:0] forced to 00.
REQ-025 SHALL give flush_i priority over branch_flag_i when both are asserted; pc <= flush_pc_i.
REQ-026 SHALL ignore redirects in IDLE; pc stays RESET_PC.
REQ-027 SHALL make the first instruction at the new target visible on id_valid_o exactly 2 cycles after the redirect cycle (fetch in cycle +1, visible in cycle +2).
REQ-028 SHALL keep head/tail pointers of log2(QDEPTH) bits wrapping naturally, and a count of log2(QDEPTH)+1 bits ranging 0..QDEPTH.

Reset
REQ-029 SHALL, while rst=0, asynchronously force: state=IDLE, pc=RESET_PC, count=0, pointers=0, rom_ce_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0.
REQ-030 SHALL discard all queue contents when rst asserts mid-operation; no stale entry is presented after release.

Verification
REQ-031 Release reset with id_ready_i=1 and the ROM holding word N = 0x1000_0000+N -> cycle 1 after release rom_ce_o=1, rom_addr_o=0; cycle 2 id_valid_o=1, id_pc_o=0, id_inst_o=0x1000_0000; PCs then advance 4, 8, 12 on consecutive cycles.
REQ-032 Hold id_ready_i=0 from the start -> exactly QDEPTH=2 pushes (PC 0, 4), then rom_ce_o=0, rom_addr_o held at 8, head stable at PC 0; raise id_ready_i -> one pop and one push in the same cycle, count stays 2.
REQ-033 With a full queue, pulse branch_flag_i with branch_target_i=0x0000_0043 -> next cycle id_valid_o=0, rom_addr_o=0x40; one cycle later id_pc_o=0x40.
REQ-034 Assert flush_i (flush_pc_i=0x0000_0180) and branch_flag_i (target 0x200) together -> pc becomes 0x180; no entry with PC 0x200 is ever presented.
REQ-035 Parameter RESET_PC=0xFFFF_FFF8 with id_ready_i=1 -> presented PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-036 Assert rst while the queue holds 2 entries -> immediately id_valid_o=0 and rom_ce_o=0; after release the first presented PC is RESET_PC.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction fetch unit: PC register, ROM request and a small in-order queue
// of {pc, instruction} entries feeding decode, with branch/exception redirect.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o
);

    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(QDEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q;
    logic [PW-1:0] head_q, tail_q;
    logic [PW:0]   count_q;
    logic [31:0]   pc_mem   [QDEPTH];
    logic [31:0]   inst_mem [QDEPTH];

    logic          redirect;
    logic          pop;
    logic          push;
    logic [31:0]   redirect_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Redirects only count once fetching has started; flush outranks branch.
    always_comb begin
        redirect    = (state_q == FETCH) && (flush_i || branch_flag_i);
        redirect_pc = flush_i ? flush_pc_i : branch_target_i;
        id_valid_o  = (count_q != '0);
        pop         = id_valid_o && id_ready_i && !redirect;
        rom_ce_o    = (state_q == FETCH) && !redirect && ((count_q < CNT_FULL) || pop);
        push        = rom_ce_o;
        id_pc_o     = id_valid_o ? pc_mem[head_q]   : 32'h0;
        id_inst_o   = id_valid_o ? inst_mem[head_q] : 32'h0;
    end

    assign rom_addr_o = pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (redirect) begin
            pc_q    <= {redirect_pc[31:2], 2'b00};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PTR_ONE;
                pc_q   <= pc_q + 32'd4;
            end
            if (pop) begin
                head_q <= head_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset: count gates visibility of every slot.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]   <= pc_q;
            inst_mem[tail_q] <= rom_inst_i;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a queue-based reference model predicts
// every fetch and every entry presented to decode, cycle by cycle.
module tb_if_fetch_queue;

    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce, flush, branch, id_valid, id_ready;
    logic [31:0] rom_addr, rom_inst, flush_pc, branch_target, id_pc, id_inst;
    logic        w_ce, w_valid;
    logic [31:0] w_addr, w_rom, w_pc, w_inst;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign rom_inst = rom_word(rom_addr);
    assign w_rom    = rom_word(w_addr);

    if_fetch_queue #(.RESET_PC(32'h0000_0000), .QDEPTH(QD)) u_dut (
        .clk(clk), .rst(rst),
        .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_inst_i(rom_inst),
        .flush_i(flush), .flush_pc_i(flush_pc),
        .branch_flag_i(branch), .branch_target_i(branch_target),
        .id_valid_o(id_valid), .id_ready_i(id_ready),
        .id_pc_o(id_pc), .id_inst_o(id_inst)
    );

    if_fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) u_wrap (
        .clk(clk), .rst(rst),
        .rom_ce_o(w_ce), .rom_addr_o(w_addr), .rom_inst_i(w_rom),
        .flush_i(1'b0), .flush_pc_i(32'h0),
        .branch_flag_i(1'b0), .branch_target_i(32'h0),
        .id_valid_o(w_valid), .id_ready_i(1'b1),
        .id_pc_o(w_pc), .id_inst_o(w_inst)
    );

    int checks   = 0;
    int failures = 0;

    // Inputs for the next cycle, applied at the falling edge.
    logic        n_rst, n_ready, n_flush, n_branch;
    logic [31:0] n_fpc, n_btgt;

    // Reference model state
    logic        m_fetch;
    logic [31:0] m_pc;
    logic [31:0] m_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fetch = 1'b0;
        m_pc    = 32'h0;
        m_q.delete();
    endtask

    task automatic cycle();
        logic        valid, redir, exp_ce;
        logic [31:0] hpc;
        @(negedge clk);
        rst           = n_rst;
        id_ready      = n_ready;
        flush         = n_flush;
        flush_pc      = n_fpc;
        branch        = n_branch;
        branch_target = n_btgt;
        #1;
        if (!rst) model_reset();
        valid  = (m_q.size() != 0);
        hpc    = valid ? m_q[0] : 32'h0;
        redir  = m_fetch && (flush || branch);
        exp_ce = m_fetch && !redir && ((m_q.size() < QD) || (valid && id_ready));
        chk("rom_ce",   32'(rom_ce),   32'(exp_ce));
        chk("rom_addr", rom_addr,      m_pc);
        chk("id_valid", 32'(id_valid), 32'(valid));
        chk("id_pc",    id_pc,         hpc);
        chk("id_inst",  id_inst,       valid ? rom_word(hpc) : 32'h0);
        if (!rst) begin
            model_reset();
        end else if (!m_fetch) begin
            m_fetch = 1'b1;
        end else if (redir) begin
            m_q.delete();
            m_pc = flush ? {flush_pc[31:2], 2'b00} : {branch_target[31:2], 2'b00};
        end else begin
            if (valid && id_ready) void'(m_q.pop_front());
            if (exp_ce) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        rst = 1'b0; id_ready = 1'b0; flush = 1'b0; branch = 1'b0;
        flush_pc = 32'h0; branch_target = 32'h0;
        n_rst = 1'b0; n_ready = 1'b1; n_flush = 1'b0; n_branch = 1'b0;
        n_fpc = 32'h0; n_btgt = 32'h0;
        model_reset();
        #1;
        chk("reset_ce",    32'(rom_ce),   32'h0);
        chk("reset_valid", 32'(id_valid), 32'h0);
        chk("reset_pc",    id_pc,         32'h0);
        chk("reset_inst",  id_inst,       32'h0);
        cycle();
        cycle();

        // Release with a branch in the idle cycle; it must be ignored.
        n_rst = 1'b1; n_branch = 1'b1; n_btgt = 32'h0000_0500;
        cycle();
        n_branch = 1'b0;
        cycle();
        chk("first_ce",   32'(rom_ce), 32'h1);
        chk("first_addr", rom_addr,    32'h0);
        cycle();
        chk("first_pc",   id_pc,   32'h0);
        chk("first_inst", id_inst, 32'h1000_0000);
        chk("wrap_pc0",   w_pc,    32'hFFFF_FFF8);
        cycle();
        chk("seq_pc4",    id_pc,   32'h4);
        chk("wrap_pc1",   w_pc,    32'hFFFF_FFFC);
        cycle();
        chk("seq_pc8",    id_pc,   32'h8);
        chk("wrap_pc2",   w_pc,    32'h0);
        chk("wrap_inst2", w_inst,  32'h1000_0000);

        // Decode stalls: queue fills, fetch stops, head holds.
        n_ready = 1'b0;
        cycle();
        cycle();
        chk("stall_ce",   32'(rom_ce), 32'h0);
        chk("stall_addr", rom_addr,    32'h14);
        chk("stall_head", id_pc,       32'hC);
        cycle();
        chk("stall_head2", id_pc, 32'hC);
        n_ready = 1'b1;
        cycle();
        chk("full_pushpop_ce", 32'(rom_ce), 32'h1);
        n_ready = 1'b0;
        cycle();
        chk("full_count_ce", 32'(rom_ce), 32'h0);
        chk("full_head",     id_pc,       32'h10);

        // Branch with a full queue, unaligned target.
        n_branch = 1'b1; n_btgt = 32'h0000_0043;
        cycle();
        n_branch = 1'b0;
        cycle();
        chk("br_valid", 32'(id_valid), 32'h0);
        chk("br_addr",  rom_addr,      32'h40);
        cycle();
        chk("br_pc",    id_pc,         32'h40);
        cycle();
        cycle();

        // Flush and branch together: flush wins.
        n_flush = 1'b1; n_fpc = 32'h0000_0180; n_branch = 1'b1; n_btgt = 32'h0000_0200;
        cycle();
        n_flush = 1'b0; n_branch = 1'b0; n_ready = 1'b1;
        cycle();
        chk("flush_addr", rom_addr, 32'h180);
        repeat (4) cycle();

        n_flush = 1'b1; n_fpc = 32'h0000_1002;
        cycle();
        n_flush = 1'b0;
        cycle();
        chk("flush_align", rom_addr, 32'h1000);

        repeat (30) begin
            n_ready  = 1'($urandom_range(0, 1));
            n_branch = ($urandom_range(0, 7) == 0);
            n_btgt   = $urandom;
            n_flush  = ($urandom_range(0, 11) == 0);
            n_fpc    = $urandom;
            cycle();
        end
        n_branch = 1'b0; n_flush = 1'b0; n_ready = 1'b0;
        repeat (3) cycle();

        // Asynchronous reset with a full queue.
        n_rst = 1'b0;
        cycle();
        chk("arst_valid", 32'(id_valid), 32'h0);
        chk("arst_ce",    32'(rom_ce),   32'h0);
        chk("arst_pc",    id_pc,         32'h0);
        cycle();
        n_rst = 1'b1; n_ready = 1'b1;
        cycle();
        cycle();
        cycle();
        chk("arst_first_valid", 32'(id_valid), 32'h1);
        chk("arst_first_pc",    id_pc,         32'h0);
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
